// File: rtl/fft_frame_sched.sv
// Frame scheduler around the streaming FFT: frames input samples, tracks output beats and frames in flight.
// Optional watchdog recovery is compiled in with `define FFT_FRAME_TIMEOUT_EN (adds err_timeout port).
module fft_frame_sched #(
    parameter int TOTAL_STAGE_P  = 6,
    parameter int MULT_WIDTH_P   = 18,
    parameter int MAX_INFLIGHT_P = 4,
    parameter int TIMEOUT_P      = 4096
) (
    input  logic                     iclk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [MULT_WIDTH_P-1:0]  s_real,
    input  logic [MULT_WIDTH_P-1:0]  s_imag,
    input  logic                     s_last,
    output logic                     fft_ien,
    output logic [TOTAL_STAGE_P-1:0] fft_iaddr,
    output logic [MULT_WIDTH_P-1:0]  fft_ireal,
    output logic [MULT_WIDTH_P-1:0]  fft_iimag,
    input  logic                     fft_oen,
    input  logic [TOTAL_STAGE_P-1:0] fft_oaddr,
    input  logic [MULT_WIDTH_P-1:0]  fft_oreal,
    input  logic [MULT_WIDTH_P-1:0]  fft_oimag,
    output logic                     m_valid,
    output logic [TOTAL_STAGE_P-1:0] m_addr,
    output logic [MULT_WIDTH_P-1:0]  m_real,
    output logic [MULT_WIDTH_P-1:0]  m_imag,
    output logic                     m_first,
    output logic                     m_last,
    output logic [3:0]               inflight,
    output logic                     err_short,
    output logic                     err_long,
`ifdef FFT_FRAME_TIMEOUT_EN
    output logic                     err_timeout,
`endif
    output logic                     err_stray
);

    localparam logic [TOTAL_STAGE_P-1:0] LAST_ADDR = '1;
    localparam logic [TOTAL_STAGE_P-1:0] ONE       = TOTAL_STAGE_P'(1);

    typedef enum logic [1:0] {IDLE, LOAD, PAD} state_t;

    state_t                   state, state_nx;
    logic [TOTAL_STAGE_P-1:0] in_cnt, in_cnt_nx;
    logic [TOTAL_STAGE_P-1:0] out_cnt;
    logic                     accept, pad_beat, start, short_frm, long_frm;
    logic                     beat_out, frame_done;
    logic [3:0]               inflight_nx;

    always_ff @(posedge iclk) begin
        if (rst) begin
            state  <= IDLE;
            in_cnt <= '0;
        end else begin
            state  <= state_nx;
            in_cnt <= in_cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_cnt_nx = in_cnt;
        s_ready   = 1'b0;
        pad_beat  = 1'b0;
        start     = 1'b0;
        short_frm = 1'b0;
        long_frm  = 1'b0;
        case (state)
            IDLE:    s_ready = !rst && (inflight < 4'(MAX_INFLIGHT_P));
            LOAD:    s_ready = !rst;
            PAD:     pad_beat = !rst;
            default: state_nx = IDLE;
        endcase
        accept = s_valid && s_ready;

        // in_cnt is 0 in IDLE, so the end-of-frame branch is only reachable from LOAD
        if (accept) begin
            start = (state == IDLE);
            if (in_cnt == LAST_ADDR) begin
                long_frm  = !s_last;
                in_cnt_nx = '0;
                state_nx  = IDLE;
            end else if (s_last) begin
                short_frm = 1'b1;
                in_cnt_nx = in_cnt + ONE;
                state_nx  = PAD;
            end else begin
                in_cnt_nx = in_cnt + ONE;
                state_nx  = LOAD;
            end
        end

        if (pad_beat) begin
            if (in_cnt == LAST_ADDR) begin
                in_cnt_nx = '0;
                state_nx  = IDLE;
            end else begin
                in_cnt_nx = in_cnt + ONE;
            end
        end
    end

    // Input beat register toward the FFT
    always_ff @(posedge iclk) begin
        if (rst) begin
            fft_ien   <= 1'b0;
            fft_iaddr <= '0;
            fft_ireal <= '0;
            fft_iimag <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            fft_ien   <= accept || pad_beat;
            err_short <= short_frm;
            err_long  <= long_frm;
            if (accept) begin
                fft_iaddr <= in_cnt;
                fft_ireal <= s_real;
                fft_iimag <= s_imag;
            end else if (pad_beat) begin
                fft_iaddr <= in_cnt;
                fft_ireal <= '0;
                fft_iimag <= '0;
            end
        end
    end

    assign beat_out    = fft_oen && (inflight != 4'd0);
    assign frame_done  = beat_out && (out_cnt == LAST_ADDR);
    assign inflight_nx = inflight + {3'b000, start} - {3'b000, frame_done};

`ifdef FFT_FRAME_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_P + 1);
    logic [WD_W-1:0] wd;
    logic            wd_fire;

    assign wd_fire = (inflight != 4'd0) && !fft_oen && (wd == WD_W'(TIMEOUT_P - 1));

    always_ff @(posedge iclk) begin
        if (rst) begin
            wd          <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= wd_fire;
            if ((inflight == 4'd0) || fft_oen || wd_fire)
                wd <= '0;
            else
                wd <= wd + WD_W'(1);
        end
    end
`else
    logic wd_fire;
    assign wd_fire = 1'b0;
`endif

    // Output side: registered result beats plus frame bookkeeping
    always_ff @(posedge iclk) begin
        if (rst) begin
            inflight  <= '0;
            out_cnt   <= '0;
            m_valid   <= 1'b0;
            m_addr    <= '0;
            m_real    <= '0;
            m_imag    <= '0;
            m_first   <= 1'b0;
            m_last    <= 1'b0;
            err_stray <= 1'b0;
        end else begin
            m_valid   <= beat_out;
            m_first   <= beat_out && (out_cnt == '0);
            m_last    <= frame_done;
            err_stray <= fft_oen && (inflight == 4'd0);
            if (beat_out) begin
                m_addr <= fft_oaddr;
                m_real <= fft_oreal;
                m_imag <= fft_oimag;
            end
            if (wd_fire) begin
                inflight <= '0;
                out_cnt  <= '0;
            end else begin
                inflight <= inflight_nx;
                if (beat_out)
                    out_cnt <= frame_done ? '0 : out_cnt + ONE;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched with a reference model and scoreboard queues on both streams.
module tb_fft_frame_sched;
    localparam int TS   = 6;
    localparam int W    = 18;
    localparam int MAXF = 4;
    localparam int N    = 1 << TS;

    logic          iclk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, s_last;
    logic [W-1:0]  s_real, s_imag;
    logic          fft_ien;
    logic [TS-1:0] fft_iaddr;
    logic [W-1:0]  fft_ireal, fft_iimag;
    logic          fft_oen;
    logic [TS-1:0] fft_oaddr;
    logic [W-1:0]  fft_oreal, fft_oimag;
    logic          m_valid, m_first, m_last;
    logic [TS-1:0] m_addr;
    logic [W-1:0]  m_real, m_imag;
    logic [3:0]    inflight;
    logic          err_short, err_long, err_stray;
`ifdef FFT_FRAME_TIMEOUT_EN
    logic          err_timeout;
`endif

    always #5 iclk = ~iclk;

    fft_frame_sched #(.TOTAL_STAGE_P(TS), .MULT_WIDTH_P(W), .MAX_INFLIGHT_P(MAXF), .TIMEOUT_P(4096)) dut (
        .iclk(iclk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
        .fft_ien(fft_ien), .fft_iaddr(fft_iaddr), .fft_ireal(fft_ireal), .fft_iimag(fft_iimag),
        .fft_oen(fft_oen), .fft_oaddr(fft_oaddr), .fft_oreal(fft_oreal), .fft_oimag(fft_oimag),
        .m_valid(m_valid), .m_addr(m_addr), .m_real(m_real), .m_imag(m_imag),
        .m_first(m_first), .m_last(m_last), .inflight(inflight),
        .err_short(err_short), .err_long(err_long),
`ifdef FFT_FRAME_TIMEOUT_EN
        .err_timeout(err_timeout),
`endif
        .err_stray(err_stray)
    );

    typedef struct packed {logic [TS-1:0] a; logic [W-1:0] r; logic [W-1:0] i;} ibeat_t;
    typedef struct packed {logic [TS-1:0] a; logic [W-1:0] r; logic [W-1:0] i; logic f; logic l;} obeat_t;

    ibeat_t in_q[$];
    obeat_t out_q[$];
    ibeat_t ie;
    obeat_t oe;
    int checks = 0;
    int errors = 0;

    // reference model state
    int mcnt = 0, ocnt = 0, minf = 0, pad_left = 0;
    bit e_s = 0, e_l = 0, e_st = 0;
    int ob_left = 0, ob_addr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard pop side, sampled 2 time units after the active edge
    always @(posedge iclk) begin
        #2;
        if (!rst) begin
            if (fft_ien) begin
                if (in_q.size() == 0) chk("ien_unexpected", 32'd1, 32'd0);
                else begin
                    ie = in_q.pop_front();
                    chk("iaddr", 32'(fft_iaddr), 32'(ie.a));
                    chk("ireal", 32'(fft_ireal), 32'(ie.r));
                    chk("iimag", 32'(fft_iimag), 32'(ie.i));
                end
            end
            if (m_valid) begin
                if (out_q.size() == 0) chk("mvalid_unexpected", 32'd1, 32'd0);
                else begin
                    oe = out_q.pop_front();
                    chk("m_addr", 32'(m_addr), 32'(oe.a));
                    chk("m_real", 32'(m_real), 32'(oe.r));
                    chk("m_imag", 32'(m_imag), 32'(oe.i));
                    chk("m_first", 32'(m_first), 32'(oe.f));
                    chk("m_last", 32'(m_last), 32'(oe.l));
                end
            end
        end
    end

    // One clock of stimulus, driven at the falling edge; the model predicts the next edge.
    task automatic cyc(input bit sv, input bit last, output bit acc);
        logic [W-1:0] re, im, ore, oim;
        bit rdy, oen;
        int inc, dec;
        re = W'($urandom); im = W'($urandom); ore = W'($urandom); oim = W'($urandom);
        oen = (ob_left > 0);
        s_valid = sv; s_last = last; s_real = re; s_imag = im;
        fft_oen = oen; fft_oaddr = TS'(ob_addr % N); fft_oreal = ore; fft_oimag = oim;
        rdy = (pad_left == 0) && (mcnt != 0 || minf < MAXF);
        chk("s_ready", 32'(s_ready), 32'(rdy));
        chk("inflight", 32'(inflight), 32'(minf));
        chk("err_short", 32'(err_short), 32'(e_s));
        chk("err_long", 32'(err_long), 32'(e_l));
        chk("err_stray", 32'(err_stray), 32'(e_st));
        e_s = 0; e_l = 0; e_st = 0; inc = 0; dec = 0; acc = 0;
        if (pad_left > 0) pad_left--;
        else if (sv && rdy) begin
            acc = 1;
            in_q.push_back('{TS'(mcnt), re, im});
            if (mcnt == 0) inc = 1;
            if (mcnt == N - 1) begin
                e_l = !last; mcnt = 0;
            end else if (last) begin
                e_s = 1;
                for (int a = mcnt + 1; a < N; a++) in_q.push_back('{TS'(a), '0, '0});
                pad_left = N - 1 - mcnt;
                mcnt = 0;
            end else mcnt++;
        end
        if (oen) begin
            ob_left--;
            if (minf > 0) begin
                out_q.push_back('{TS'(ob_addr % N), ore, oim, ocnt == 0, ocnt == N - 1});
                if (ocnt == N - 1) begin dec = 1; ocnt = 0; end
                else ocnt++;
            end else e_st = 1;
            ob_addr++;
        end
        minf = minf + inc - dec;
        @(negedge iclk);
    endtask

    task automatic send_frame(input int n, input bit with_last, input bit gaps);
        int k = 0, guard = 0;
        bit a;
        while (k < n && guard < 2000) begin
            if (gaps && $urandom_range(0, 3) == 0) cyc(0, 0, a);
            else begin
                cyc(1, with_last && (k == n - 1), a);
                if (a) k++;
            end
            guard++;
        end
        if (k < n) chk("send_timeout", 32'(k), 32'(n));
    endtask

    task automatic idle(input int c);
        bit a;
        repeat (c) cyc(0, 0, a);
    endtask

    initial begin
        bit a;
        rst = 1; s_valid = 0; s_last = 0; s_real = '0; s_imag = '0;
        fft_oen = 0; fft_oaddr = '0; fft_oreal = '0; fft_oimag = '0;
        repeat (3) @(negedge iclk);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_ien", 32'(fft_ien), 0);
        chk("rst_mvalid", 32'(m_valid), 0);
        chk("rst_inflight", 32'(inflight), 0);
        chk("rst_errs", 32'({err_short, err_long, err_stray}), 0);
        rst = 0;
        @(negedge iclk);

        // full frame, continuous valid
        send_frame(N, 1, 0);
        idle(2);
        // short frame: s_last on sample 9, zero padding to the end
        send_frame(10, 1, 0);
        idle(N);
        // long frame followed by a frame that must restart at address 0
        send_frame(N, 0, 0);
        send_frame(N, 1, 0);
        chk("full_inflight", 32'(inflight), MAXF);
        // fifth frame stalls until one frame of results drains
        repeat (20) cyc(1, 0, a);
        ob_left = N; ob_addr = 0;
        send_frame(N, 1, 1);
        ob_left = 2 * N;
        idle(2 * N + 2);
        chk("drained_to_2", 32'(inflight), 2);
        // frame start coinciding with the last output beat of a frame
        ob_left = N - 1;
        idle(N - 1);
        ob_left = 1;
        send_frame(N, 1, 0);
        ob_left = 2 * N;
        idle(2 * N + 4);
        chk("empty_inflight", 32'(inflight), 0);
        // stray output beat
        ob_left = 1;
        cyc(0, 0, a);
        chk("stray_mvalid", 32'(m_valid), 0);
        chk("stray_pulse", 32'(err_stray), 1);
        idle(2);
        // single-sample frame, then reset in the middle of a frame
        send_frame(1, 1, 0);
        idle(N);
        send_frame(10, 0, 0);
        rst = 1; s_valid = 0; fft_oen = 0;
        repeat (2) @(negedge iclk);
        chk("midrst_inflight", 32'(inflight), 0);
        in_q.delete(); out_q.delete();
        mcnt = 0; ocnt = 0; minf = 0; pad_left = 0; e_s = 0; e_l = 0; e_st = 0; ob_left = 0;
        rst = 0;
        @(negedge iclk);
        send_frame(N, 1, 1);
        idle(3);
        chk("in_q_empty", 32'(in_q.size()), 0);
        chk("out_q_empty", 32'(out_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
